// File: rtl/instr_serial_loader.sv
// Serialises 13-bit instruction words LSB-first onto the one-bit processor's load port.
// Latency: first load_bit the cycle after start; upstream backpressure via word_ready (FIFO full or DRAIN).
// Optional LOADER_CHECKSUM_EN: per-program XOR of shifted words on checksum, else checksum tied to 0.
module instr_serial_loader #(
    parameter int INSTR_WIDTH = 13,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_WORDS   = 1000,
    parameter int CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   word_valid,
    input  logic [INSTR_WIDTH-1:0] word_data,
    input  logic                   word_last,
    output logic                   word_ready,
    output logic                   load_en,
    output logic                   load_bit,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       word_count,
    output logic                   overflow,
    output logic                   underrun,
    output logic [INSTR_WIDTH-1:0] checksum
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(INSTR_WIDTH);
    localparam logic [BW-1:0]    BIT_LAST = BW'(INSTR_WIDTH - 1);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      ONE_CNT  = (AW+1)'(1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    typedef struct packed {
        logic                   last;
        logic [INSTR_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DRAIN} state_t;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    state_t          state;
    logic [BW-1:0]   bit_idx;

    entry_t          head;
    logic            full;
    logic            has_last;
    logic            start;
    logic            wrap;
    logic            push;
    logic            pop;
    logic            next_bit;
    logic            next_avail;
    logic [BW-1:0]   bit_nxt;
    logic [CNT_W-1:0] wc_inc;

    assign head       = mem[rd_ptr];
    assign full       = (count == FULL_CNT);
    assign wrap       = (state == SHIFT) && (bit_idx == BIT_LAST);
    assign pop        = wrap || ((state == DRAIN) && (count != '0));
    // A full FIFO still takes a word on the edge its head is popped.
    assign word_ready = !reset && (state != DRAIN) && (!full || wrap);
    assign push       = word_valid && word_ready;
    assign bit_nxt    = bit_idx + 1'b1;
    assign wc_inc     = word_count + 1'b1;
    assign busy       = (state != IDLE);
    assign start      = full || has_last;

    always_comb begin
        has_last = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (((AW+1)'(i) < count) && mem[rd_ptr + AW'(i)].last) begin
                has_last = 1'b1;
            end
        end
    end

    // Word following the head after the wrap pop; a word pushed on that same edge qualifies.
    always_comb begin
        next_bit   = mem[rd_ptr + 1'b1].data[0];
        next_avail = 1'b1;
        if (count == ONE_CNT) begin
            next_bit   = word_data[0];
            next_avail = push;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{last: word_last, data: word_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            load_en    <= 1'b0;
            load_bit   <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SHIFT;
                        bit_idx    <= '0;
                        load_en    <= 1'b1;
                        load_bit   <= head.data[0];
                        word_count <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_idx != BIT_LAST) begin
                        bit_idx  <= bit_nxt;
                        load_bit <= head.data[bit_nxt];
                    end else begin
                        bit_idx    <= '0;
                        word_count <= wc_inc;
                        if (head.last) begin
                            state    <= FINISH;
                            load_en  <= 1'b0;
                            load_bit <= 1'b0;
                            done     <= 1'b1;
                        end else if (wc_inc == MAX_CNT) begin
                            overflow <= 1'b1;
                            state    <= DRAIN;
                            load_en  <= 1'b0;
                            load_bit <= 1'b0;
                        end else if (!next_avail) begin
                            underrun <= 1'b1;
                            state    <= FINISH;
                            load_en  <= 1'b0;
                            load_bit <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            load_bit <= next_bit;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    // Discard the rest of the oversized program up to its last word.
                    if ((count != '0) && head.last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if ((state == IDLE) && start) begin
            checksum <= '0;
        end else if (wrap) begin
            checksum <= checksum ^ head.data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_serial_loader.sv
// Directed bench for instr_serial_loader: single-word table plus multi-word, underrun, reset and overflow sequences.
module tb_instr_serial_loader;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         word_valid = 1'b0;
    logic [W-1:0] word_data = '0;
    logic         word_last = 1'b0;
    logic         sel = 1'b0;

    logic a_ready, a_en, a_bit, a_busy, a_done, a_ovf, a_und;
    logic [9:0] a_wc;
    logic [W-1:0] a_cs;
    logic b_ready, b_en, b_bit, b_busy, b_done, b_ovf, b_und;
    logic [9:0] b_wc;
    logic [W-1:0] b_cs;

    always #5 clk = ~clk;

    instr_serial_loader dut_a (
        .clk(clk), .reset(reset),
        .word_valid(word_valid && !sel), .word_data(word_data), .word_last(word_last),
        .word_ready(a_ready), .load_en(a_en), .load_bit(a_bit), .busy(a_busy), .done(a_done),
        .word_count(a_wc), .overflow(a_ovf), .underrun(a_und), .checksum(a_cs)
    );

    instr_serial_loader #(.MAX_WORDS(3)) dut_b (
        .clk(clk), .reset(reset),
        .word_valid(word_valid && sel), .word_data(word_data), .word_last(word_last),
        .word_ready(b_ready), .load_en(b_en), .load_bit(b_bit), .busy(b_busy), .done(b_done),
        .word_count(b_wc), .overflow(b_ovf), .underrun(b_und), .checksum(b_cs)
    );

    wire         m_ready = sel ? b_ready : a_ready;
    wire         m_en    = sel ? b_en    : a_en;
    wire         m_bit   = sel ? b_bit   : a_bit;
    wire         m_busy  = sel ? b_busy  : a_busy;
    wire         m_done  = sel ? b_done  : a_done;
    wire         m_ovf   = sel ? b_ovf   : a_ovf;
    wire         m_und   = sel ? b_und   : a_und;
    wire [9:0]   m_wc    = sel ? b_wc    : a_wc;
    wire [W-1:0] m_cs    = sel ? b_cs    : a_cs;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } word_t;

    typedef struct {
        logic [W-1:0] data;
        int           exp_cycles;
        logic [W-1:0] exp_bits;
        int           exp_wc;
    } vec_t;

    word_t send_q[$];
    vec_t  tbl[5];

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int en_cycles, windows, done_cnt, gap, gap_min, first_en, first_push, last_push, nbits;
    logic prev_en;
    logic [W-1:0] bits;

    function automatic logic [W-1:0] exp_cs(input logic [W-1:0] x);
`ifdef LOADER_CHECKSUM_EN
        return x;
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic clear_stats();
        en_cycles = 0; windows = 0; done_cnt = 0; gap = 0; gap_min = 1000;
        first_en = -1; first_push = -1; last_push = -1; nbits = 0; bits = '0; prev_en = 1'b0;
    endtask

    task automatic step();
        logic fire;
        fire = word_valid && m_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            if (first_push < 0) first_push = cyc;
            last_push = cyc;
            void'(send_q.pop_front());
        end
        if (m_en) begin
            en_cycles++;
            if (!prev_en) begin
                windows++;
                if (windows > 1 && gap < gap_min) gap_min = gap;
                if (first_en < 0) first_en = cyc;
            end
            if (nbits < W) begin
                bits[nbits] = m_bit;
                nbits++;
            end
            gap = 0;
        end else begin
            gap++;
        end
        if (m_done) done_cnt++;
        prev_en = m_en;
        word_valid = (send_q.size() != 0);
        if (send_q.size() != 0) begin
            word_data = send_q[0].data;
            word_last = send_q[0].last;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(name, int'(done_cnt >= target), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{13'h1A5B, 13, 13'b1_1010_0101_1011, 1};
        tbl[1] = '{13'h0000, 13, 13'b0_0000_0000_0000, 1};
        tbl[2] = '{13'h1FFF, 13, 13'b1_1111_1111_1111, 1};
        tbl[3] = '{13'h0AAA, 13, 13'b0_1010_1010_1010, 1};
        tbl[4] = '{13'h1001, 13, 13'b1_0000_0000_0001, 1};

        clear_stats();
        step();
        step();
        check("ready_during_reset", m_ready, 0);
        check("load_en_during_reset", m_en, 0);
        reset = 1'b0;
        #1;
        check("reset_ready", m_ready, 1);
        check("reset_busy", m_busy, 0);
        check("reset_done", m_done, 0);
        check("reset_word_count", m_wc, 0);
        check("reset_overflow", m_ovf, 0);
        check("reset_underrun", m_und, 0);
        check("reset_checksum", m_cs, 0);

        for (int i = 0; i < 5; i++) begin
            clear_stats();
            send_q.push_back('{1'b1, tbl[i].data});
            wait_done(1, 100, $sformatf("single%0d_done", i));
            check($sformatf("single%0d_en_cycles", i), en_cycles, tbl[i].exp_cycles);
            check($sformatf("single%0d_windows", i), windows, 1);
            check($sformatf("single%0d_bits", i), bits, tbl[i].exp_bits);
            check($sformatf("single%0d_word_count", i), m_wc, tbl[i].exp_wc);
            check($sformatf("single%0d_latency", i), first_en - first_push, 1);
            check($sformatf("single%0d_checksum", i), m_cs, exp_cs(tbl[i].data));
            step();
            check($sformatf("single%0d_idle", i), m_busy, 0);
            check($sformatf("single%0d_done_once", i), done_cnt, 1);
        end

        clear_stats();
        for (int i = 1; i <= 6; i++) send_q.push_back('{(i == 6), 13'(i)});
        wait_done(1, 300, "six_done");
        check("six_en_cycles", en_cycles, 78);
        check("six_windows", windows, 1);
        check("six_word_count", m_wc, 6);
        check("six_underrun", m_und, 0);
        check("six_overflow", m_ovf, 0);
        check("six_checksum", m_cs, exp_cs(13'h0007));

        clear_stats();
        send_q.push_back('{1'b0, 13'h0101});
        send_q.push_back('{1'b1, 13'h0202});
        send_q.push_back('{1'b1, 13'h0404});
        wait_done(2, 300, "two_prog_done");
        step();
        step();
        check("two_prog_windows", windows, 2);
        check("two_prog_en_cycles", en_cycles, 39);
        check("two_prog_gap", int'(gap_min >= 1), 1);
        check("two_prog_done_pulses", done_cnt, 2);
        check("two_prog_word_count", m_wc, 1);

        begin
            int n;
            clear_stats();
            send_q.push_back('{1'b1, 13'h0F0F});
            n = 0;
            while (en_cycles < 7 && n < 100) begin
                step();
                n++;
            end
            check("midreset_reach_bit7", en_cycles, 7);
            reset = 1'b1;
            step();
            reset = 1'b0;
            #1;
            check("midreset_load_en", m_en, 0);
            check("midreset_busy", m_busy, 0);
            check("midreset_ready", m_ready, 1);
            clear_stats();
            for (int k = 0; k < 20; k++) step();
            check("midreset_no_more_bits", en_cycles, 0);
            clear_stats();
            send_q.push_back('{1'b1, 13'h1A5B});
            wait_done(1, 100, "midreset_reload_done");
            check("midreset_reload_bits", bits, 13'b1_1010_0101_1011);
            check("midreset_reload_en_cycles", en_cycles, 13);
        end

        clear_stats();
        for (int i = 1; i <= 4; i++) send_q.push_back('{1'b0, 13'(16 * i)});
        wait_done(1, 300, "underrun_done");
        check("underrun_start_on_full", first_en - last_push, 1);
        check("underrun_en_cycles", en_cycles, 52);
        check("underrun_flag", m_und, 1);
        check("underrun_word_count", m_wc, 4);
        check("underrun_windows", windows, 1);

        sel = 1'b1;
        #1;
        clear_stats();
        for (int i = 1; i <= 5; i++) send_q.push_back('{(i == 5), 13'(16 + i)});
        wait_done(1, 300, "overflow_done");
        check("overflow_en_cycles", en_cycles, 39);
        check("overflow_flag", m_ovf, 1);
        check("overflow_word_count", m_wc, 3);
        check("overflow_windows", windows, 1);
        check("overflow_underrun", m_und, 0);
        check("overflow_checksum", m_cs, exp_cs(13'h0010));
        step();
        check("overflow_idle", m_busy, 0);
        check("overflow_drained_ready", m_ready, 1);
        check("overflow_sticky", m_ovf, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
